// File: rtl/logs_r_scheduler.sv
// Logistic-map r sequencer: dwell per r, mute while the map settles after
// each r change, with hold and skip controls.
module logs_r_scheduler #(
    parameter int FRAC      = 8,
    parameter int R_INC     = 1000,
    parameter int SETTLE    = 64,
    parameter int STEP_LO   = 4,
    parameter int STEP_HI   = 1,
    parameter int INITIAL_R = (1 << FRAC) | (1 << (FRAC - 4))
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            iter_done,
    input  logic            hold,
    input  logic            skip,
    output logic [FRAC+1:0] r,
    output logic            r_load,
    output logic            mute,
    output logic [1:0]      state
);

    localparam int CMAX = (R_INC > SETTLE) ? R_INC : SETTLE;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0]   SET_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   PLAY_LAST = CW'(R_INC - 1);
    localparam logic [FRAC+1:0] R_INIT    = INITIAL_R[FRAC+1:0];
    localparam logic [FRAC+2:0] INC_LO    = STEP_LO[FRAC+2:0];
    localparam logic [FRAC+2:0] INC_HI    = STEP_HI[FRAC+2:0];

    typedef enum logic [1:0] {
        S_SETTLE = 2'b00,
        S_PLAY   = 2'b01,
        S_STEP   = 2'b10
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [FRAC+2:0] w_inc;
    logic [FRAC+2:0] w_sum;
    logic [FRAC+1:0] w_next;

    // Increment picked from r before the add, so 0x2FC steps by 4 to 0x300
    assign w_inc  = (r[FRAC+1:FRAC] < 2'b11) ? INC_LO : INC_HI;
    assign w_sum  = {1'b0, r} + w_inc;
    assign w_next = w_sum[FRAC+2] ? R_INIT : w_sum[FRAC+1:0];
    assign state  = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
            r       <= R_INIT;
            r_load  <= 1'b0;
            mute    <= 1'b1;
        end else begin
            r_load <= 1'b0;
            unique case (r_state)
                S_SETTLE: begin
                    if (skip) begin
                        r_state <= S_STEP;
                        mute    <= 1'b1;
                    end else if (iter_done) begin
                        if (r_cnt == SET_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_PLAY;
                            mute    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (skip) begin
                        r_state <= S_STEP;
                        mute    <= 1'b1;
                    end else if (iter_done && !hold) begin
                        if (r_cnt == PLAY_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_STEP;
                            mute    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    r       <= w_next;
                    r_load  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                    mute    <= 1'b1;
                end
                default: begin
                    r_state <= S_SETTLE;
                    r_cnt   <= '0;
                    mute    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logs_r_scheduler.sv
// Bench for logs_r_scheduler: vector table, directed sequences and a
// randomized run against an iteration-counting reference model.
module tb_logs_r_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       iter_done = 1'b0;
    logic       hold = 1'b0;
    logic       skip = 1'b0;
    logic [9:0] r;
    logic       r_load;
    logic       mute;
    logic [1:0] state;

    int total = 0;
    int bad = 0;

    logs_r_scheduler dut (
        .clk(clk), .reset_n(reset_n), .iter_done(iter_done),
        .hold(hold), .skip(skip), .r(r), .r_load(r_load),
        .mute(mute), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       it;
        logic       hd;
        logic       sk;
        logic [1:0] e_state;
        logic       e_mute;
        logic       e_load;
        logic [9:0] e_r;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic outs(input string nm, input int er, input int el,
                        input int em, input int es);
        chk({nm, ".r"}, 32'(r), er);
        chk({nm, ".load"}, 32'(r_load), el);
        chk({nm, ".mute"}, 32'(mute), em);
        chk({nm, ".state"}, 32'(state), es);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            iter_done = 1'b1;
            tick();
        end
        iter_done = 1'b0;
    endtask

    task automatic do_reset();
        iter_done = 0; hold = 0; skip = 0;
        reset_n = 1'b0;
        tick();
        tick();
        outs("reset", 'h110, 0, 1, 0);
        reset_n = 1'b1;
    endtask

    // Spec-level r progression: +4 below 3.0, +1 above, wrap to 1.0625 at 4.0
    function automatic int r_after(input int rv);
        int n;
        n = rv + ((rv < 'h300) ? 4 : 1);
        return (n >= 'h400) ? 'h110 : n;
    endfunction

    // Reference model: which phase we are in and iterations consumed in it
    int m_r, m_phase, m_done, m_load;

    task automatic model_edge(input logic it, input logic hd, input logic sk);
        m_load = 0;
        if (m_phase == 2) begin
            m_r = r_after(m_r);
            m_load = 1;
            m_phase = 0;
            m_done = 0;
        end else if (sk) begin
            m_phase = 2;
        end else if (m_phase == 0 && it) begin
            m_done++;
            if (m_done == 64) begin m_done = 0; m_phase = 1; end
        end else if (m_phase == 1 && it && !hd) begin
            m_done++;
            if (m_done == 1000) begin m_done = 0; m_phase = 2; end
        end
    endtask

    initial begin
        vec_t tbl[6];
        int   e, p;

        tbl[0] = '{0, 0, 1, 2'b10, 1, 0, 10'h110};
        tbl[1] = '{1, 0, 1, 2'b00, 1, 1, 10'h114};
        tbl[2] = '{1, 0, 0, 2'b00, 1, 0, 10'h114};
        tbl[3] = '{0, 0, 1, 2'b10, 1, 0, 10'h114};
        tbl[4] = '{0, 0, 0, 2'b00, 1, 1, 10'h118};
        tbl[5] = '{1, 1, 0, 2'b00, 1, 0, 10'h118};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            iter_done = tbl[i].it; hold = tbl[i].hd; skip = tbl[i].sk;
            tick();
            outs($sformatf("vec%0d", i), tbl[i].e_r, tbl[i].e_load,
                 tbl[i].e_mute, tbl[i].e_state);
        end
        iter_done = 0; hold = 0; skip = 0;

        // Settle of 64 then a 1000-iteration dwell
        do_reset();
        for (int i = 0; i < 64; i++) begin
            iter_done = 1'b1;
            tick();
            chk("settle.r", r, 'h110);
            chk("settle.mute", mute, (i == 63) ? 0 : 1);
            chk("settle.state", state, (i == 63) ? 1 : 0);
        end
        pulse(999);
        outs("play999", 'h110, 0, 0, 1);
        pulse(1);
        outs("dwell.step", 'h110, 0, 1, 2);
        tick();
        outs("dwell.new", 'h114, 1, 1, 0);
        tick();
        outs("dwell.after", 'h114, 0, 1, 0);

        // Hold freezes the dwell count
        pulse(64);
        pulse(500);
        hold = 1'b1;
        pulse(300);
        outs("hold", 'h114, 0, 0, 1);
        hold = 1'b0;
        pulse(499);
        outs("hold.rel499", 'h114, 0, 0, 1);
        pulse(1);
        outs("hold.step", 'h114, 0, 1, 2);
        tick();
        outs("hold.new", 'h118, 1, 1, 0);

        // Skip with a concurrent iter_done mid-dwell
        pulse(64);
        pulse(500);
        skip = 1'b1; iter_done = 1'b1;
        tick();
        skip = 1'b0; iter_done = 1'b0;
        outs("skip.step", 'h118, 0, 1, 2);
        tick();
        outs("skip.new", 'h11c, 1, 1, 0);
        pulse(63);
        outs("skip.cnt63", 'h11c, 0, 1, 0);
        pulse(1);
        outs("skip.play", 'h11c, 0, 0, 1);
        pulse(999);
        outs("skip.p999", 'h11c, 0, 0, 1);
        pulse(1);
        outs("skip.p1000", 'h11c, 0, 1, 2);

        // Asynchronous reset landing on the r_load cycle
        tick();
        outs("ar.pre", 'h120, 1, 1, 0);
        #2 reset_n = 1'b0;
        #1 outs("async", 'h110, 0, 1, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        outs("ar.first", 'h110, 0, 1, 0);

        // Full sweep driven by skips, including the 3.0 boundary and wrap
        do_reset();
        e = 'h110;
        for (int k = 0; k < 600; k++) begin
            p = e;
            skip = 1'b1;
            tick();
            skip = 1'b0;
            tick();
            e = r_after(p);
            chk("sweep.r", r, e);
            chk("sweep.load", r_load, 1);
            if (p == 'h2fc) chk("b.2fc", r, 'h300);
            if (p == 'h300) chk("b.300", r, 'h301);
            if (p == 'h3ff) begin
                chk("b.wrap", r, 'h110);
                break;
            end
        end
        chk("sweep.end", e, 'h110);

        // Randomized run against the reference model
        do_reset();
        m_r = 'h110; m_phase = 0; m_done = 0; m_load = 0;
        for (int c = 0; c < 20000; c++) begin
            iter_done = ($urandom_range(0, 1) == 1);
            hold      = ($urandom_range(0, 7) == 0);
            skip      = ($urandom_range(0, 499) == 0);
            @(posedge clk);
            model_edge(iter_done, hold, skip);
            #1;
            chk("rnd.r", r, m_r);
            chk("rnd.load", r_load, m_load);
            chk("rnd.mute", mute, (m_phase == 1) ? 0 : 1);
            chk("rnd.state", state, m_phase);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
